// File: rtl/stat_spill_recorder.sv
// ---------------------------------------------------------------------------
// stat_spill_recorder
//
// Sits between the veto statistics counter and the slow-control register
// bank. Every time the live window closes (in_live 1->0) a record holding
// the spill ID, the veto count seen in that cycle, the live-window length
// and (optionally) a timestamp is pushed into a small record FIFO. The
// readout side drains records with a valid/ready handshake, so a slow
// readout never loses a spill unless the FIFO is completely full.
//
// Optional feature macro:
//   STAT_REC_TIMESTAMP_EN - when defined, a free-running 32-bit cycle
//                           counter is sampled into every record and shown
//                           on rd_ts. When undefined, no timestamp logic is
//                           built and rd_ts is tied to zero.
// ---------------------------------------------------------------------------
module stat_spill_recorder #(
    parameter int DEPTH = 8,
    parameter int ID_W  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_live,
    input  logic [31:0]     in_veto_cnt,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [ID_W-1:0] rd_spill_id,
    output logic [31:0]     rd_veto_cnt,
    output logic [31:0]     rd_live_len,
    output logic [31:0]     rd_ts,
    output logic [6:0]      fifo_level,
    output logic [15:0]     ovf_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [6:0]    LEVEL_MAX = 7'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        LIVE = 1'b1
    } state_t;

    // Window tracking
    state_t          state_q;
    logic            pre_live_q;
    logic [31:0]     live_len_q;
    logic            rise;
    logic            fall;

    // Record bookkeeping
    logic [ID_W-1:0] spill_id_q;
    logic [ID_W-1:0] spill_id_d;
    logic [15:0]     ovf_cnt_q;
    logic [15:0]     ovf_cnt_d;

    // FIFO pointers and occupancy
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   rd_ptr_d;
    logic [6:0]      level_q;
    logic [6:0]      level_d;

    // Record storage, one array per field
    logic [ID_W-1:0] mem_id_q   [DEPTH];
    logic [31:0]     mem_veto_q [DEPTH];
    logic [31:0]     mem_len_q  [DEPTH];

    // Handshake and push/pop decisions
    logic            push;
    logic            pop;
    logic            full;
    logic            wr_en;
    logic            drop;

`ifdef STAT_REC_TIMESTAMP_EN
    logic [31:0]     ts_q;
    logic [31:0]     mem_ts_q [DEPTH];
`endif

    assign rise = in_live & ~pre_live_q;
    assign fall = ~in_live & pre_live_q;

    // Delayed copy of in_live for edge detection; cleared by reset so a
    // window that is already open at release is seen as a fresh start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_live_q <= 1'b0;
        end else begin
            pre_live_q <= in_live;
        end
    end

    // Window FSM: measures the live-window length, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            live_len_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q    <= LIVE;
                        live_len_q <= 32'd1;
                    end
                end
                LIVE: begin
                    if (fall) begin
                        state_q <= IDLE;
                    end else if (in_live && (live_len_q != 32'hFFFF_FFFF)) begin
                        live_len_q <= live_len_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Push/pop arbitration; a pop on a full FIFO frees the slot the push uses.
    always_comb begin
        push  = fall && (state_q == LIVE);
        pop   = rd_valid && rd_ready;
        full  = (level_q == LEVEL_MAX);
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;
    end

    // Next-state values for pointers, occupancy, spill ID and drop counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        spill_id_d = spill_id_q;
        ovf_cnt_d  = ovf_cnt_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_en, pop})
            2'b10:   level_d = level_q + 7'd1;
            2'b01:   level_d = level_q - 7'd1;
            default: level_d = level_q;
        endcase

        if (push) begin
            spill_id_d = spill_id_q + ID_W'(1);
        end
        if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    // Control registers for the FIFO and the per-spill counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= 7'd0;
            spill_id_q <= '0;
            ovf_cnt_q  <= 16'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            spill_id_q <= spill_id_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    // Record storage; cleared on reset so the head reads as zero when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_id_q[i]   <= '0;
                mem_veto_q[i] <= 32'd0;
                mem_len_q[i]  <= 32'd0;
            end
        end else if (wr_en) begin
            mem_id_q[wr_ptr_q]   <= spill_id_q;
            mem_veto_q[wr_ptr_q] <= in_veto_cnt;
            mem_len_q[wr_ptr_q]  <= live_len_q;
        end
    end

`ifdef STAT_REC_TIMESTAMP_EN
    // Free-running cycle counter and its per-record snapshot storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_ts_q[i] <= 32'd0;
            end
        end else begin
            ts_q <= ts_q + 32'd1;
            if (wr_en) begin
                mem_ts_q[wr_ptr_q] <= ts_q;
            end
        end
    end

    assign rd_ts = mem_ts_q[rd_ptr_q];
`else
    assign rd_ts = 32'd0;
`endif

    assign rd_valid    = (level_q != 7'd0);
    assign rd_spill_id = mem_id_q[rd_ptr_q];
    assign rd_veto_cnt = mem_veto_q[rd_ptr_q];
    assign rd_live_len = mem_len_q[rd_ptr_q];
    assign fifo_level  = level_q;
    assign ovf_cnt     = ovf_cnt_q;

endmodule

// File: tb/tb_stat_spill_recorder.sv
// ---------------------------------------------------------------------------
// tb_stat_spill_recorder
//
// Drives live windows into stat_spill_recorder and keeps a scoreboard of the
// records the FIFO should hold. Expected records are queued when a window
// closes and popped when the bench drains the head of the DUT FIFO.
// Honours STAT_REC_TIMESTAMP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_stat_spill_recorder;

    localparam int DEPTH = 8;
    localparam int ID_W  = 16;

    typedef struct packed {
        logic [15:0] id;
        logic [31:0] veto;
        logic [31:0] len;
    } rec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_live = 1'b0;
    logic [31:0]     in_veto_cnt = 32'd0;
    logic            rd_ready = 1'b0;
    logic            rd_valid;
    logic [ID_W-1:0] rd_spill_id;
    logic [31:0]     rd_veto_cnt;
    logic [31:0]     rd_live_len;
    logic [31:0]     rd_ts;
    logic [6:0]      fifo_level;
    logic [15:0]     ovf_cnt;

    int   n_cmp = 0;
    int   n_bad = 0;
    rec_t sb[$];
    int   exp_level = 0;
    int   exp_ovf = 0;
    int   next_id = 0;

    stat_spill_recorder #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_live     (in_live),
        .in_veto_cnt (in_veto_cnt),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_spill_id (rd_spill_id),
        .rd_veto_cnt (rd_veto_cnt),
        .rd_live_len (rd_live_len),
        .rd_ts       (rd_ts),
        .fifo_level  (fifo_level),
        .ovf_cnt     (ovf_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Open a window of 'len' cycles, close it, and update the scoreboard.
    // With pop_at_fall the head is popped in the same cycle as the close.
    task automatic run_window(input int len, input logic [31:0] veto, input bit pop_at_fall,
                              output rec_t obs_head, output rec_t exp_head);
        rec_t r;
        in_live     = 1'b1;
        in_veto_cnt = veto;
        repeat (len) tick();
        in_live  = 1'b0;
        obs_head = '0;
        exp_head = '0;
        if (pop_at_fall) begin
            obs_head.id   = rd_spill_id;
            obs_head.veto = rd_veto_cnt;
            obs_head.len  = rd_live_len;
            rd_ready      = 1'b1;
            if (exp_level > 0) begin
                exp_head  = sb.pop_front();
                exp_level = exp_level - 1;
            end
        end
        r.id   = 16'(next_id);
        r.veto = veto;
        r.len  = 32'(len);
        if (exp_level < DEPTH) begin
            sb.push_back(r);
            exp_level = exp_level + 1;
        end else if (exp_ovf < 65535) begin
            exp_ovf = exp_ovf + 1;
        end
        next_id = (next_id + 1) % 65536;
        tick();
        rd_ready = 1'b0;
    endtask

    // Capture the DUT head and accept it with a one-cycle ready pulse.
    task automatic pop_head(output rec_t obs, output logic [31:0] ts, output rec_t exp_r);
        obs.id   = rd_spill_id;
        obs.veto = rd_veto_cnt;
        obs.len  = rd_live_len;
        ts       = rd_ts;
        exp_r    = '0;
        if (sb.size() > 0) begin
            exp_r = sb.pop_front();
        end
        if (exp_level > 0) begin
            exp_level = exp_level - 1;
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        in_live = 1'b0;
        sb.delete();
        exp_level = 0;
        exp_ovf   = 0;
        next_id   = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %0b expected 0", rd_valid); end
        n_cmp++; if (fifo_level !== 7'd0) begin n_bad++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level); end
        n_cmp++; if (ovf_cnt !== 16'd0) begin n_bad++; $display("[TB] FAIL reset_ovf: got %0d expected 0", ovf_cnt); end
        n_cmp++; if (rd_spill_id !== 16'd0) begin n_bad++; $display("[TB] FAIL reset_id: got %0h expected 0", rd_spill_id); end
        n_cmp++; if (rd_veto_cnt !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_veto: got %0h expected 0", rd_veto_cnt); end
        n_cmp++; if (rd_live_len !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_len: got %0h expected 0", rd_live_len); end
        n_cmp++; if (rd_ts !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_ts: got %0h expected 0", rd_ts); end
    endtask

    task automatic test_single_window();
        rec_t obs, exp_r, dummy_o, dummy_e;
        logic [31:0] ts;
        run_window(100, 32'd5, 1'b0, dummy_o, dummy_e);
        n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL single_valid: got %0b expected 1", rd_valid); end
        n_cmp++; if (fifo_level !== 7'd1) begin n_bad++; $display("[TB] FAIL single_level: got %0d expected 1", fifo_level); end
        pop_head(obs, ts, exp_r);
        n_cmp++; if (obs.id !== 16'd0) begin n_bad++; $display("[TB] FAIL single_id: got %0d expected 0", obs.id); end
        n_cmp++; if (obs.veto !== 32'd5) begin n_bad++; $display("[TB] FAIL single_veto: got %0d expected 5", obs.veto); end
        n_cmp++; if (obs.len !== 32'd100) begin n_bad++; $display("[TB] FAIL single_len: got %0d expected 100", obs.len); end
        n_cmp++; if (obs !== exp_r) begin n_bad++; $display("[TB] FAIL single_record: got %h expected %h", obs, exp_r); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL single_empty: got %0b expected 0", rd_valid); end
    endtask

    task automatic test_overflow();
        rec_t obs, exp_r, dummy_o, dummy_e;
        logic [31:0] ts;
        for (int i = 0; i < 9; i++) begin
            run_window(3 + i, 32'd100 + 32'(i), 1'b0, dummy_o, dummy_e);
        end
        n_cmp++; if (fifo_level !== 7'(exp_level)) begin n_bad++; $display("[TB] FAIL ovf_level: got %0d expected %0d", fifo_level, exp_level); end
        n_cmp++; if (ovf_cnt !== 16'(exp_ovf)) begin n_bad++; $display("[TB] FAIL ovf_count: got %0d expected %0d", ovf_cnt, exp_ovf); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_drain_valid[%0d]: got %0b expected 1", i, rd_valid); end
            pop_head(obs, ts, exp_r);
            n_cmp++; if (obs !== exp_r) begin n_bad++; $display("[TB] FAIL ovf_drain[%0d]: got %h expected %h", i, obs, exp_r); end
        end
        n_cmp++; if (fifo_level !== 7'd0) begin n_bad++; $display("[TB] FAIL ovf_drained_level: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_push_pop_full();
        rec_t obs, exp_r, head_o, head_e, dummy_o, dummy_e;
        logic [31:0] ts;
        for (int i = 0; i < DEPTH; i++) begin
            run_window(2 + i, 32'd200 + 32'(i), 1'b0, dummy_o, dummy_e);
        end
        n_cmp++; if (fifo_level !== 7'd8) begin n_bad++; $display("[TB] FAIL ppf_full: got %0d expected 8", fifo_level); end
        run_window(7, 32'd777, 1'b1, head_o, head_e);
        n_cmp++; if (head_o !== head_e) begin n_bad++; $display("[TB] FAIL ppf_popped: got %h expected %h", head_o, head_e); end
        n_cmp++; if (ovf_cnt !== 16'(exp_ovf)) begin n_bad++; $display("[TB] FAIL ppf_ovf: got %0d expected %0d", ovf_cnt, exp_ovf); end
        n_cmp++; if (fifo_level !== 7'd8) begin n_bad++; $display("[TB] FAIL ppf_level: got %0d expected 8", fifo_level); end
        for (int i = 0; i < DEPTH; i++) begin
            pop_head(obs, ts, exp_r);
            n_cmp++; if (obs !== exp_r) begin n_bad++; $display("[TB] FAIL ppf_drain[%0d]: got %h expected %h", i, obs, exp_r); end
        end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL ppf_empty: got %0b expected 0", rd_valid); end
    endtask

    task automatic test_stall();
        rec_t obs, exp_r, dummy_o, dummy_e;
        logic [31:0] ts;
        run_window(4, 32'd31, 1'b0, dummy_o, dummy_e);
        run_window(6, 32'd47, 1'b0, dummy_o, dummy_e);
        for (int i = 0; i < 20; i++) begin
            obs.id   = rd_spill_id;
            obs.veto = rd_veto_cnt;
            obs.len  = rd_live_len;
            n_cmp++; if ((obs !== sb[0]) || (rd_valid !== 1'b1)) begin
                n_bad++; $display("[TB] FAIL stall_hold[%0d]: got %h valid %0b expected %h valid 1", i, obs, rd_valid, sb[0]);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            pop_head(obs, ts, exp_r);
            n_cmp++; if (obs !== exp_r) begin n_bad++; $display("[TB] FAIL stall_drain[%0d]: got %h expected %h", i, obs, exp_r); end
        end
    endtask

    task automatic test_reset_mid_window();
        rec_t obs, exp_r, dummy_o, dummy_e;
        logic [31:0] ts;
        run_window(3, 32'd9, 1'b0, dummy_o, dummy_e);
        in_live = 1'b1;
        repeat (10) tick();
        rst_n = 1'b0;
        sb.delete();
        exp_level = 0;
        exp_ovf   = 0;
        next_id   = 0;
        repeat (3) tick();
        n_cmp++; if (fifo_level !== 7'd0) begin n_bad++; $display("[TB] FAIL rmw_level_in_reset: got %0d expected 0", fifo_level); end
        rst_n = 1'b1;
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rmw_valid_at_release: got %0b expected 0", rd_valid); end
        run_window(30, 32'd12, 1'b0, dummy_o, dummy_e);
        n_cmp++; if (fifo_level !== 7'd1) begin n_bad++; $display("[TB] FAIL rmw_level: got %0d expected 1", fifo_level); end
        pop_head(obs, ts, exp_r);
        n_cmp++; if (obs.len !== 32'd30) begin n_bad++; $display("[TB] FAIL rmw_len: got %0d expected 30", obs.len); end
        n_cmp++; if (obs !== exp_r) begin n_bad++; $display("[TB] FAIL rmw_record: got %h expected %h", obs, exp_r); end
    endtask

    task automatic test_timestamp();
        rec_t obs1, obs2, exp1, exp2, dummy_o, dummy_e;
        logic [31:0] ts1, ts2;
        run_window(10, 32'd1, 1'b0, dummy_o, dummy_e);
        repeat (149) tick();
        run_window(50, 32'd2, 1'b0, dummy_o, dummy_e);
        pop_head(obs1, ts1, exp1);
        pop_head(obs2, ts2, exp2);
        n_cmp++; if (obs1 !== exp1) begin n_bad++; $display("[TB] FAIL ts_rec1: got %h expected %h", obs1, exp1); end
        n_cmp++; if (obs2 !== exp2) begin n_bad++; $display("[TB] FAIL ts_rec2: got %h expected %h", obs2, exp2); end
`ifdef STAT_REC_TIMESTAMP_EN
        n_cmp++; if ((ts2 - ts1) !== 32'd200) begin n_bad++; $display("[TB] FAIL ts_delta: got %0d expected 200", ts2 - ts1); end
`else
        n_cmp++; if (ts1 !== 32'd0) begin n_bad++; $display("[TB] FAIL ts_zero1: got %0h expected 0", ts1); end
        n_cmp++; if (ts2 !== 32'd0) begin n_bad++; $display("[TB] FAIL ts_zero2: got %0h expected 0", ts2); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_window();
        test_overflow();
        test_push_pop_full();
        test_stall();
        test_reset_mid_window();
        test_timestamp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
